regfile_writeback: RTL and testbench



---
 rtl/regfile_writeback.sv | 138 +++++++++++++
 tb/tb_regfile_writeback.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - two-pipe write-back FIFOs, round-robin register file write and pending scoreboard
// Optional same-cycle source bypass outputs when TPU_WB_BYPASS_EN is defined.
module regfile_writeback #(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 6,
    parameter int NUM_REG    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_Valid_A,
    input  logic [IDX_W-1:0]  I_Dst_A,
    input  logic [DATA_W-1:0] I_Data_A,
    output logic              O_Rdy_A,
    input  logic              I_Valid_B,
    input  logic [IDX_W-1:0]  I_Dst_B,
    input  logic [DATA_W-1:0] I_Data_B,
    output logic              O_Rdy_B,
    input  logic              I_Issue,
    input  logic [IDX_W-1:0]  I_Issue_Dst,
    input  logic [IDX_W-1:0]  I_Index_Src1,
    input  logic [IDX_W-1:0]  I_Index_Src2,
    output logic              O_Pend_Src1,
    output logic              O_Pend_Src2,
`ifdef TPU_WB_BYPASS_EN
    output logic              O_Byp_Src1,
    output logic              O_Byp_Src2,
    output logic [DATA_W-1:0] O_Byp_Data1,
    output logic [DATA_W-1:0] O_Byp_Data2,
`endif
    output logic              O_We,
    output logic [IDX_W-1:0]  O_Index_Dst,
    output logic [DATA_W-1:0] O_Data,
    output logic              O_Idle
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int PTR_W    = AW + 1;
    localparam int EW       = IDX_W + DATA_W;
    localparam int FULL_REG = 1 << IDX_W;

    logic [EW-1:0]    mem_a [FIFO_DEPTH];
    logic [EW-1:0]    mem_b [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_a, rd_a, wr_b, rd_b;
    logic             empty_a, empty_b, full_a, full_b;
    logic             push_a, push_b, grant_a, grant_b;
    logic             last_b;
    logic [EW-1:0]    head_a, head_b;
    logic [NUM_REG-1:0]  pend;
    logic [FULL_REG-1:0] pend_ext;
    logic             pend_raw1, pend_raw2;

    // Pointer MSB differing with equal low bits means the FIFO has wrapped full.
    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);
    assign full_a  = (wr_a[AW] != rd_a[AW]) && (wr_a[AW-1:0] == rd_a[AW-1:0]);
    assign full_b  = (wr_b[AW] != rd_b[AW]) && (wr_b[AW-1:0] == rd_b[AW-1:0]);

    assign O_Rdy_A = !full_a;
    assign O_Rdy_B = !full_b;
    assign push_a  = I_Valid_A && !full_a;
    assign push_b  = I_Valid_B && !full_b;

    assign grant_a = !empty_a && (empty_b || last_b);
    assign grant_b = !empty_b && !grant_a;

    assign head_a = mem_a[rd_a[AW-1:0]];
    assign head_b = mem_b[rd_b[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push_a) mem_a[wr_a[AW-1:0]] <= {I_Dst_A, I_Data_A};
        if (push_b) mem_b[wr_b[AW-1:0]] <= {I_Dst_B, I_Data_B};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_a        <= '0;
            rd_a        <= '0;
            wr_b        <= '0;
            rd_b        <= '0;
            last_b      <= 1'b1;
            O_We        <= 1'b0;
            O_Index_Dst <= '0;
            O_Data      <= '0;
        end else begin
            if (push_a) wr_a <= wr_a + PTR_W'(1);
            if (push_b) wr_b <= wr_b + PTR_W'(1);
            O_We <= grant_a || grant_b;
            if (grant_a) begin
                rd_a                  <= rd_a + PTR_W'(1);
                last_b                <= 1'b0;
                {O_Index_Dst, O_Data} <= head_a;
            end else if (grant_b) begin
                rd_b                  <= rd_b + PTR_W'(1);
                last_b                <= 1'b1;
                {O_Index_Dst, O_Data} <= head_b;
            end
        end
    end

    // Issue takes priority so a re-reservation during the landing write stays pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REG; i++) begin
                if (I_Issue && (I_Issue_Dst == IDX_W'(i)))
                    pend[i] <= 1'b1;
                else if (O_We && (O_Index_Dst == IDX_W'(i)))
                    pend[i] <= 1'b0;
            end
        end
    end

    generate
        if (NUM_REG < FULL_REG) begin : g_pad
            assign pend_ext = {{(FULL_REG - NUM_REG){1'b0}}, pend};
        end else begin : g_nopad
            assign pend_ext = pend;
        end
    endgenerate

    assign pend_raw1 = pend_ext[I_Index_Src1];
    assign pend_raw2 = pend_ext[I_Index_Src2];

`ifdef TPU_WB_BYPASS_EN
    assign O_Byp_Src1  = O_We && (O_Index_Dst == I_Index_Src1);
    assign O_Byp_Src2  = O_We && (O_Index_Dst == I_Index_Src2);
    assign O_Byp_Data1 = O_Data;
    assign O_Byp_Data2 = O_Data;
    assign O_Pend_Src1 = pend_raw1 && !O_Byp_Src1;
    assign O_Pend_Src2 = pend_raw2 && !O_Byp_Src2;
`else
    assign O_Pend_Src1 = pend_raw1;
    assign O_Pend_Src2 = pend_raw2;
`endif

    assign O_Idle = empty_a && empty_b && !O_We;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback (also built with TPU_WB_BYPASS_EN)
module tb_regfile_writeback;
    localparam int DW = 32, IW = 6, NR = 48, DEPTH = 4;

    logic clock = 1'b0, reset = 1'b1;
    logic I_Valid_A = 0, I_Valid_B = 0, I_Issue = 0;
    logic [IW-1:0] I_Dst_A = 0, I_Dst_B = 0, I_Issue_Dst = 0, I_Index_Src1 = 0, I_Index_Src2 = 0;
    logic [DW-1:0] I_Data_A = 0, I_Data_B = 0;
    logic O_Rdy_A, O_Rdy_B, O_Pend_Src1, O_Pend_Src2, O_We, O_Idle;
    logic [IW-1:0] O_Index_Dst;
    logic [DW-1:0] O_Data;
`ifdef TPU_WB_BYPASS_EN
    logic O_Byp_Src1, O_Byp_Src2;
    logic [DW-1:0] O_Byp_Data1, O_Byp_Data2;
`endif

    regfile_writeback #(.DATA_W(DW), .IDX_W(IW), .NUM_REG(NR), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .I_Valid_A(I_Valid_A), .I_Dst_A(I_Dst_A), .I_Data_A(I_Data_A), .O_Rdy_A(O_Rdy_A),
        .I_Valid_B(I_Valid_B), .I_Dst_B(I_Dst_B), .I_Data_B(I_Data_B), .O_Rdy_B(O_Rdy_B),
        .I_Issue(I_Issue), .I_Issue_Dst(I_Issue_Dst),
        .I_Index_Src1(I_Index_Src1), .I_Index_Src2(I_Index_Src2),
        .O_Pend_Src1(O_Pend_Src1), .O_Pend_Src2(O_Pend_Src2),
`ifdef TPU_WB_BYPASS_EN
        .O_Byp_Src1(O_Byp_Src1), .O_Byp_Src2(O_Byp_Src2),
        .O_Byp_Data1(O_Byp_Data1), .O_Byp_Data2(O_Byp_Data2),
`endif
        .O_We(O_We), .O_Index_Dst(O_Index_Dst), .O_Data(O_Data), .O_Idle(O_Idle)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    int enq_a = 0, enq_b = 0, a_wr = 0, b_wr = 0;
    bit chk_occ = 0, saw_full_a = 0, saw_full_b = 0;
    logic [IW+DW-1:0] qa[$], qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input bit pb, input int n, input logic [IW-1:0] dst0, input logic [DW-1:0] d0);
        int i = 0;
        int guard = 0;
        bit acc = 0;
        logic [IW-1:0] d;
        logic [DW-1:0] v;
        forever begin
            @(negedge clock);
            if (i >= n || guard > 300) begin
                if (pb) I_Valid_B = 0; else I_Valid_A = 0;
                break;
            end
            d = dst0 + IW'(i);
            v = d0 + DW'(i);
            if (pb) begin I_Valid_B = 1; I_Dst_B = d; I_Data_B = v; acc = O_Rdy_B; end
            else    begin I_Valid_A = 1; I_Dst_A = d; I_Data_A = v; acc = O_Rdy_A; end
            @(posedge clock);
            guard++;
            if (acc) begin
                if (pb) begin qb.push_back({d, v}); enq_b++; end
                else    begin qa.push_back({d, v}); enq_a++; end
                i++;
            end
        end
        if (i < n) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: got %0d accepted expected %0d", i, n);
        end
    endtask

    // Monitor: port B results carry 0xB in the top data nibble, everything else belongs to port A.
    always @(negedge clock) begin
        logic [IW+DW-1:0] e;
        if (O_We) begin
            if (O_Data[31:28] == 4'hB) begin
                b_wr++;
                if (qb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write_b: got %0h:%0h expected none", O_Index_Dst, O_Data);
                end else begin
                    e = qb.pop_front();
                    chk("write_b", {O_Index_Dst, O_Data}, e);
                end
            end else begin
                a_wr++;
                if (qa.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write_a: got %0h:%0h expected none", O_Index_Dst, O_Data);
                end else begin
                    e = qa.pop_front();
                    chk("write_a", {O_Index_Dst, O_Data}, e);
                end
            end
        end
        if (chk_occ) begin
            chk("rdy_a_vs_occ", O_Rdy_A, (enq_a - a_wr) != DEPTH);
            chk("rdy_b_vs_occ", O_Rdy_B, (enq_b - b_wr) != DEPTH);
            if (!O_Rdy_A) saw_full_a = 1;
            if (!O_Rdy_B) saw_full_b = 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, b0, w0;
        I_Index_Src1 = 7;
        repeat (3) @(negedge clock);
        chk("rst_we", O_We, 0);
        chk("rst_idx", O_Index_Dst, 0);
        chk("rst_data", O_Data, 0);
        chk("rst_rdy_a", O_Rdy_A, 1);
        chk("rst_rdy_b", O_Rdy_B, 1);
        chk("rst_idle", O_Idle, 1);
        chk("rst_pend", O_Pend_Src1, 0);
        reset = 0;

        // Contention from reset: strict A,B alternation, 16 back-to-back writes.
        fork
            send(0, 8, 6'd1, 32'hA000_0001);
            send(1, 8, 6'd9, 32'hB000_0009);
            begin
                bit seen = 0;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clock);
                    if (O_We) begin seen = 1; break; end
                end
                chk("alt_start_seen", seen, 1);
                for (int j = 0; j < 16; j++) begin
                    if (j > 0) @(negedge clock);
                    chk("alt_we", O_We, 1);
                    chk("alt_port", O_Data[31:28], (j % 2) ? 4'hB : 4'hA);
                end
            end
        join
        repeat (3) @(negedge clock);
        chk("t2_drained", qa.size() + qb.size(), 0);

        // Single write latency.
        send(0, 1, 6'd5, 32'hDEADBEEF);
        chk("lat_we_early", O_We, 0);
        @(negedge clock);
        chk("lat_we", O_We, 1);
        chk("lat_idx", O_Index_Dst, 5);
        chk("lat_data", O_Data, 32'hDEADBEEF);
        chk("lat_idle_busy", O_Idle, 0);
        @(negedge clock);
        chk("lat_idle_back", O_Idle, 1);
        chk("lat_we_off", O_We, 0);

        // A fills to DEPTH under contention; pointers wrap.
        a0 = a_wr; b0 = b_wr;
        chk_occ = 1;
        fork
            send(1, 20, 6'd24, 32'hB000_0024);
            begin
                repeat (2) @(negedge clock);
                send(0, 10, 6'd44, 32'hA000_0044);
            end
        join
        repeat (30) @(negedge clock);
        chk_occ = 0;
        chk("full_a_seen", saw_full_a, 1);
        chk("full_b_seen", saw_full_b, 1);
        chk("t3_a_count", a_wr - a0, 10);
        chk("t3_b_count", b_wr - b0, 20);
        chk("t3_drained", qa.size() + qb.size(), 0);

        // Scoreboard set/clear and bypass window.
        I_Index_Src1 = 7; I_Index_Src2 = 7;
        #1 chk("pend_before_issue", O_Pend_Src1, 0);
        I_Issue = 1; I_Issue_Dst = 7;
        @(negedge clock);
        I_Issue = 0;
        chk("pend_issued", O_Pend_Src1, 1);
        send(0, 1, 6'd7, 32'hA000_0077);
        chk("pend_queued", O_Pend_Src1, 1);
        @(negedge clock);
        chk("wb7_we", O_We, 1);
`ifdef TPU_WB_BYPASS_EN
        chk("byp_src2", O_Byp_Src2, 1);
        chk("byp_data2", O_Byp_Data2, 32'hA000_0077);
        chk("byp_pend2", O_Pend_Src2, 0);
        chk("byp_pend1", O_Pend_Src1, 0);
`else
        chk("nobyp_pend2", O_Pend_Src2, 1);
        chk("nobyp_pend1", O_Pend_Src1, 1);
`endif
        @(negedge clock);
        chk("pend_cleared", O_Pend_Src1, 0);
        I_Issue = 1; I_Issue_Dst = 7;
        @(negedge clock);
        I_Issue = 0;
        chk("pend_reissued", O_Pend_Src1, 1);
        send(0, 1, 6'd7, 32'hA000_0078);
        @(negedge clock);
        chk("wb7b_we", O_We, 1);
        I_Issue = 1; I_Issue_Dst = 7;
        @(negedge clock);
        I_Issue = 0;
        chk("set_wins", O_Pend_Src1, 1);
        @(negedge clock);
        chk("set_wins_hold", O_Pend_Src1, 1);

        // Indices at and beyond NUM_REG.
        I_Index_Src2 = 50; I_Issue = 1; I_Issue_Dst = 50;
        @(negedge clock);
        I_Issue_Dst = 47;
        @(negedge clock);
        I_Issue = 0;
        chk("pend_out_of_range", O_Pend_Src2, 0);
        I_Index_Src2 = 47;
        #1 chk("pend_last_reg", O_Pend_Src2, 1);

        // Reset mid-operation with queued entries and pending bits.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            I_Valid_A = 1; I_Dst_A = IW'(60 + k); I_Data_A = 32'hA000_00C0 + DW'(k);
            I_Valid_B = 1; I_Dst_B = IW'(56 + k); I_Data_B = 32'hB000_00C0 + DW'(k);
            qa.push_back({I_Dst_A, I_Data_A});
            qb.push_back({I_Dst_B, I_Data_B});
            @(posedge clock);
        end
        #1 chk("we_before_reset", O_We, 1);
        #1 reset = 1;
        #1 chk("reset_we_async", O_We, 0);
        chk("reset_idle_async", O_Idle, 1);
        chk("reset_pend_async", O_Pend_Src1, 0);
        @(negedge clock);
        I_Valid_A = 0; I_Valid_B = 0;
        qa.delete(); qb.delete();
        repeat (2) @(negedge clock);
        reset = 0;
        w0 = a_wr + b_wr;
        repeat (8) @(negedge clock);
        chk("no_stale_write", a_wr + b_wr - w0, 0);
        chk("post_reset_idle", O_Idle, 1);
        chk("post_reset_pend1", O_Pend_Src1, 0);
        chk("post_reset_pend2", O_Pend_Src2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
